// File: rtl/id_ex_pipe_pkg.sv
// Shared widths, load-type codes and pipeline-slot actions for the ID/EX register.
package id_ex_pipe_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int LD_TYPE_WIDTH = 3;
  localparam int ALU_OP_WIDTH  = 5;
  localparam int CNT_WIDTH     = 32;

  // Kept at zero so a cleared slot reads as "no load" without special casing.
  localparam logic [LD_TYPE_WIDTH-1:0] LD_XXX = '0;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } slot_act_e;

endpackage

// File: rtl/id_ex_pipe_reg.sv
// One pipeline field: synchronous reset and clear to zero, load when enabled.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every field samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush/hold/bubble control and a saturating bubble counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = id_ex_pipe_pkg::DATA_WIDTH,
  parameter int RF_ADDR_WIDTH = id_ex_pipe_pkg::RF_ADDR_WIDTH,
  parameter int LD_TYPE_WIDTH = id_ex_pipe_pkg::LD_TYPE_WIDTH,
  parameter int ALU_OP_WIDTH  = id_ex_pipe_pkg::ALU_OP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Decode_Valid,
  input  logic [DATA_WIDTH-1:0]    Decode_Pc,
  input  logic [DATA_WIDTH-1:0]    Decode_Imm,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr,
  input  logic                     Decode_WbRdEn,
  input  logic [LD_TYPE_WIDTH-1:0] Decode_LdType,
  input  logic                     Decode_StEn,
  input  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs2Data,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs3Data,
  input  logic                     DecodeHazard_StallReq,
  input  logic                     Ctrl_Flush,
  input  logic                     Ex_StallReq,
  output logic                     IDEX_Valid,
  output logic [DATA_WIDTH-1:0]    IDEX_Pc,
  output logic [DATA_WIDTH-1:0]    IDEX_Imm,
  output logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr,
  output logic                     IDEX_WbRdEn,
  output logic [LD_TYPE_WIDTH-1:0] IDEX_LdType,
  output logic                     IDEX_StEn,
  output logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs1Data,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs2Data,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs3Data,
  output logic [31:0]              IDEX_BubbleCnt
);

  slot_act_e   act;
  logic        en;
  logic        clr;
  logic [31:0] bubble_cnt;

  // NOTE: default assigned first so no path through this block can infer a latch.
  always_comb begin
    act = ACT_LOAD;
    if (Ctrl_Flush)                                  act = ACT_FLUSH;
    else if (Ex_StallReq)                            act = ACT_HOLD;
    else if (DecodeHazard_StallReq || !Decode_Valid) act = ACT_BUBBLE;
  end

  // A cleared slot carries LD_XXX (zero) and WbRdEn=0, so forwarding never matches it.
  assign clr = (act == ACT_FLUSH) || (act == ACT_BUBBLE);
  assign en  = (act == ACT_LOAD);

  pipe_reg #(.WIDTH(1)) u_valid (.clk, .rst_n, .en, .clr, .d(1'b1), .q(IDEX_Valid));
  pipe_reg #(.WIDTH(DATA_WIDTH)) u_pc (.clk, .rst_n, .en, .clr, .d(Decode_Pc), .q(IDEX_Pc));
  pipe_reg #(.WIDTH(DATA_WIDTH)) u_imm (.clk, .rst_n, .en, .clr, .d(Decode_Imm), .q(IDEX_Imm));
  pipe_reg #(.WIDTH(RF_ADDR_WIDTH)) u_rd (.clk, .rst_n, .en, .clr, .d(Decode_RdAddr), .q(IDEX_RdAddr));
  pipe_reg #(.WIDTH(1)) u_wb (.clk, .rst_n, .en, .clr, .d(Decode_WbRdEn), .q(IDEX_WbRdEn));
  pipe_reg #(.WIDTH(LD_TYPE_WIDTH)) u_ld (.clk, .rst_n, .en, .clr, .d(Decode_LdType), .q(IDEX_LdType));
  pipe_reg #(.WIDTH(1)) u_st (.clk, .rst_n, .en, .clr, .d(Decode_StEn), .q(IDEX_StEn));
  pipe_reg #(.WIDTH(ALU_OP_WIDTH)) u_alu (.clk, .rst_n, .en, .clr, .d(Decode_AluOp), .q(IDEX_AluOp));
  pipe_reg #(.WIDTH(DATA_WIDTH)) u_rs1 (.clk, .rst_n, .en, .clr, .d(DecodeHazard_Rs1Data), .q(IDEX_Rs1Data));
  pipe_reg #(.WIDTH(DATA_WIDTH)) u_rs2 (.clk, .rst_n, .en, .clr, .d(DecodeHazard_Rs2Data), .q(IDEX_Rs2Data));
  pipe_reg #(.WIDTH(DATA_WIDTH)) u_rs3 (.clk, .rst_n, .en, .clr, .d(DecodeHazard_Rs3Data), .q(IDEX_Rs3Data));

  // Only load-use bubbles count; idle decode slots (Decode_Valid=0) do not.
  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (act == ACT_BUBBLE && DecodeHazard_StallReq && bubble_cnt != 32'hFFFF_FFFF)
      bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign IDEX_BubbleCnt = bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     Decode_Valid;
  logic [DATA_WIDTH-1:0]    Decode_Pc, Decode_Imm;
  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr;
  logic                     Decode_WbRdEn;
  logic [LD_TYPE_WIDTH-1:0] Decode_LdType;
  logic                     Decode_StEn;
  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp;
  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data, DecodeHazard_Rs2Data, DecodeHazard_Rs3Data;
  logic                     DecodeHazard_StallReq, Ctrl_Flush, Ex_StallReq;
  logic                     IDEX_Valid;
  logic [DATA_WIDTH-1:0]    IDEX_Pc, IDEX_Imm;
  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr;
  logic                     IDEX_WbRdEn;
  logic [LD_TYPE_WIDTH-1:0] IDEX_LdType;
  logic                     IDEX_StEn;
  logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp;
  logic [DATA_WIDTH-1:0]    IDEX_Rs1Data, IDEX_Rs2Data, IDEX_Rs3Data;
  logic [31:0]              IDEX_BubbleCnt;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .Decode_Valid(Decode_Valid), .Decode_Pc(Decode_Pc), .Decode_Imm(Decode_Imm),
    .Decode_RdAddr(Decode_RdAddr), .Decode_WbRdEn(Decode_WbRdEn), .Decode_LdType(Decode_LdType),
    .Decode_StEn(Decode_StEn), .Decode_AluOp(Decode_AluOp),
    .DecodeHazard_Rs1Data(DecodeHazard_Rs1Data), .DecodeHazard_Rs2Data(DecodeHazard_Rs2Data),
    .DecodeHazard_Rs3Data(DecodeHazard_Rs3Data), .DecodeHazard_StallReq(DecodeHazard_StallReq),
    .Ctrl_Flush(Ctrl_Flush), .Ex_StallReq(Ex_StallReq),
    .IDEX_Valid(IDEX_Valid), .IDEX_Pc(IDEX_Pc), .IDEX_Imm(IDEX_Imm), .IDEX_RdAddr(IDEX_RdAddr),
    .IDEX_WbRdEn(IDEX_WbRdEn), .IDEX_LdType(IDEX_LdType), .IDEX_StEn(IDEX_StEn),
    .IDEX_AluOp(IDEX_AluOp), .IDEX_Rs1Data(IDEX_Rs1Data), .IDEX_Rs2Data(IDEX_Rs2Data),
    .IDEX_Rs3Data(IDEX_Rs3Data), .IDEX_BubbleCnt(IDEX_BubbleCnt)
  );

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    imm;
    logic [RF_ADDR_WIDTH-1:0] rd;
    logic                     wb;
    logic [LD_TYPE_WIDTH-1:0] ld;
    logic                     st;
    logic [ALU_OP_WIDTH-1:0]  alu;
    logic [DATA_WIDTH-1:0]    rs1;
    logic [DATA_WIDTH-1:0]    rs2;
    logic [DATA_WIDTH-1:0]    rs3;
    logic [31:0]              cnt;
  } slot_t;

  slot_t model;
  slot_t exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    stim_done = 1'b0;

  // Reference model: the architectural effect of one clock edge given the inputs now on the pins.
  function automatic slot_t next_slot(slot_t s);
    slot_t n;
    n = '0;
    n.ld = LD_XXX;
    if (!rst_n) return n;
    n.cnt = s.cnt;
    if (Ctrl_Flush) return n;
    if (Ex_StallReq) return s;
    if (DecodeHazard_StallReq || !Decode_Valid) begin
      if (DecodeHazard_StallReq && s.cnt != 32'hFFFF_FFFF) n.cnt = s.cnt + 1;
      return n;
    end
    n.valid = 1'b1;
    n.pc = Decode_Pc;   n.imm = Decode_Imm;   n.rd = Decode_RdAddr;
    n.wb = Decode_WbRdEn; n.ld = Decode_LdType; n.st = Decode_StEn;
    n.alu = Decode_AluOp; n.rs1 = DecodeHazard_Rs1Data;
    n.rs2 = DecodeHazard_Rs2Data; n.rs3 = DecodeHazard_Rs3Data;
    return n;
  endfunction

  task automatic set_ctrl(input bit rst, input bit flush, input bit exs, input bit hz, input bit vld);
    rst_n = rst; Ctrl_Flush = flush; Ex_StallReq = exs;
    DecodeHazard_StallReq = hz; Decode_Valid = vld;
  endtask

  task automatic rand_data();
    Decode_Pc = {$urandom, $urandom};  Decode_Imm = {$urandom, $urandom};
    Decode_RdAddr = RF_ADDR_WIDTH'($urandom); Decode_WbRdEn = 1'($urandom);
    Decode_LdType = LD_TYPE_WIDTH'($urandom); Decode_StEn = 1'($urandom);
    Decode_AluOp = ALU_OP_WIDTH'($urandom);
    DecodeHazard_Rs1Data = {$urandom, $urandom};
    DecodeHazard_Rs2Data = {$urandom, $urandom};
    DecodeHazard_Rs3Data = {$urandom, $urandom};
  endtask

  // Inputs must already be on the pins (driven after a negedge); records the expected post-edge state.
  task automatic commit(input string name);
    model = next_slot(model);
    exp_q.push_back(model);
    name_q.push_back(name);
  endtask

  task automatic cycle(input string name, input bit rst, input bit flush, input bit exs,
                       input bit hz, input bit vld);
    @(negedge clk);
    rand_data();
    set_ctrl(rst, flush, exs, hz, vld);
    commit(name);
  endtask

  // Monitor: the slot is presented every cycle, so compare one expectation per edge.
  initial begin
    slot_t got, exp;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = '{IDEX_Valid, IDEX_Pc, IDEX_Imm, IDEX_RdAddr, IDEX_WbRdEn, IDEX_LdType,
                IDEX_StEn, IDEX_AluOp, IDEX_Rs1Data, IDEX_Rs2Data, IDEX_Rs3Data, IDEX_BubbleCnt};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s: got=%h exp=%h", nm, got, exp);
        end
      end
    end
  end

  initial begin
    model = '0;
    rand_data();
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    cycle("reset", 0, 0, 0, 0, 1);
    cycle("reset", 0, 1, 1, 1, 1);

    // Single load with known values.
    @(negedge clk);
    rand_data();
    set_ctrl(1, 0, 0, 0, 1);
    Decode_Pc = 64'h1000; Decode_RdAddr = 5'd5; Decode_WbRdEn = 1'b1;
    DecodeHazard_Rs1Data = 64'hAA;
    commit("load_basic");

    cycle("load_use_1", 1, 0, 0, 1, 1);
    cycle("load_use_2", 1, 0, 0, 1, 1);

    // Hold keeps the loaded slot and does not count while a load-use stall is also raised.
    @(negedge clk);
    rand_data();
    set_ctrl(1, 0, 0, 0, 1);
    Decode_Pc = 64'h2000;
    commit("hold_load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_data();
      set_ctrl(1, 0, 1, 1, 1);
      Decode_Pc = 64'h3000;
      commit("hold");
    end

    cycle("flush_prio_load", 1, 0, 0, 0, 1);
    cycle("flush_prio", 1, 1, 1, 0, 1);
    cycle("idle_no_count", 1, 0, 0, 0, 0);

    // Build the counter to 7, then reset in the middle of a hold.
    while (model.cnt < 7) cycle("count_up", 1, 0, 0, 1, 1);
    cycle("pre_hold_load", 1, 0, 0, 0, 1);
    cycle("mid_hold", 1, 0, 1, 1, 1);
    cycle("reset_mid_hold", 0, 0, 1, 1, 1);
    cycle("load_after_reset", 1, 0, 0, 0, 1);

    // Saturation: preset the counter just below its ceiling, then stall twice.
    @(negedge clk);
    rand_data();
    set_ctrl(1, 0, 0, 1, 1);
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt;
    model.cnt = 32'hFFFF_FFFE;
    commit("sat_1");
    cycle("sat_2", 1, 0, 0, 1, 1);
    cycle("sat_3", 1, 0, 0, 1, 1);
    cycle("sat_load", 1, 0, 0, 0, 1);

    // Randomized traffic mixing every priority level.
    for (int i = 0; i < 400; i++) begin
      cycle("random",
            ($urandom_range(99) >= 3),
            ($urandom_range(99) < 10),
            ($urandom_range(99) < 20),
            ($urandom_range(99) < 25),
            ($urandom_range(99) < 80));
    end

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, register/operand data width.
REQ-002 SHALL have parameter RF_ADDR_WIDTH, 5, register-file address width.
REQ-003 SHALL have parameter LD_TYPE_WIDTH, 3, load-type code width; code LD_XXX means "no load".
REQ-004 SHALL have parameter ALU_OP_WIDTH, 5, ALU opcode width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have inputs Decode_Valid (1), Decode_Pc (DATA_WIDTH), Decode_Imm (DATA_WIDTH): decoded instruction valid, PC, immediate.
REQ-008 SHALL have inputs Decode_RdAddr (RF_ADDR_WIDTH), Decode_WbRdEn (1), Decode_LdType (LD_TYPE_WIDTH), Decode_StEn (1), Decode_AluOp (ALU_OP_WIDTH).
REQ-009 SHALL have inputs DecodeHazard_Rs1Data, DecodeHazard_Rs2Data, DecodeHazard_Rs3Data (DATA_WIDTH each): forwarded operands.
REQ-010 SHALL have input DecodeHazard_StallReq (1): load-use stall, bubble required.
REQ-011 SHALL have input Ctrl_Flush (1): branch/exception flush of the ID/EX slot.
REQ-012 SHALL have input Ex_StallReq (1): execute stage busy (multi-cycle op), hold ID/EX contents.
REQ-013 SHALL have outputs IDEX_Valid, IDEX_Pc, IDEX_Imm, IDEX_RdAddr, IDEX_WbRdEn, IDEX_LdType, IDEX_StEn, IDEX_AluOp, IDEX_Rs1Data, IDEX_Rs2Data, IDEX_Rs3Data, widths matching their Decode_/DecodeHazard_ sources, all registered.
REQ-014 SHALL have output IDEX_BubbleCnt  output  32  saturating count of inserted bubbles.

Function
REQ-015 SHALL resolve each cycle with fixed priority: reset > FLUSH > HOLD > BUBBLE > LOAD.
REQ-016 FLUSH (Ctrl_Flush=1): next cycle all outputs except IDEX_BubbleCnt SHALL be zero, IDEX_LdType = LD_XXX.
REQ-017 HOLD (Ex_StallReq=1, no flush): all pipeline outputs SHALL retain their values; inputs ignored.
REQ-018 BUBBLE (DecodeHazard_StallReq=1 or Decode_Valid=0, no flush/hold): pipeline outputs SHALL load the flush value of REQ-016.
REQ-019 LOAD (otherwise): every IDEX_ output SHALL capture its source one cycle later; IDEX_Valid=1.
REQ-020 Latency Decode->IDEX SHALL be exactly one cycle in LOAD; no combinational path input->output.
REQ-021 A bubble or flush SHALL clear IDEX_WbRdEn so the forwarding unit never matches a non-instruction.
REQ-022 IDEX_BubbleCnt SHALL increment by 1 only on a BUBBLE cycle caused by DecodeHazard_StallReq=1 (not Decode_Valid=0), and SHALL saturate at 0xFFFF_FFFF.
REQ-023 IDEX_BubbleCnt SHALL not change on FLUSH or HOLD cycles.
REQ-024 Ctrl_Flush with Ex_StallReq simultaneous: flush SHALL win; Ex_StallReq with DecodeHazard_StallReq: hold SHALL win, no count.
REQ-025 Consecutive stall cycles SHALL each insert a bubble and each increment the counter.

Reset
REQ-026 With rst_n=0 at a rising edge, all pipeline outputs SHALL take the flush value of REQ-016 and IDEX_BubbleCnt SHALL be 0.
REQ-027 Reset asserted mid-HOLD or mid-stall SHALL override all other inputs in that cycle.
REQ-028 First cycle after reset release SHALL behave per REQ-015 with no extra idle cycle.

Structure
REQ-029 LD_XXX, widths DATA_WIDTH, RF_ADDR_WIDTH, LD_TYPE_WIDTH, ALU_OP_WIDTH SHALL come from the shared Define.v package.
REQ-030 One sub-module pipe_reg (parameter WIDTH; en, clr, reset value 0) SHALL implement each field; id_ex_pipe derives en/clr from REQ-015.
REQ-031 Bubble counter SHALL live in id_ex_pipe, not in pipe_reg.

Verification
REQ-032 LOAD: Decode_Valid=1, Pc=0x1000, RdAddr=5, WbRdEn=1, Rs1Data=0xAA -> next cycle IDEX_Pc=0x1000, IDEX_RdAddr=5, IDEX_Rs1Data=0xAA, IDEX_Valid=1.
REQ-033 Load-use: DecodeHazard_StallReq=1 for 2 cycles -> IDEX_Valid=0, IDEX_WbRdEn=0, IDEX_LdType=LD_XXX both cycles; IDEX_BubbleCnt 0->2.
REQ-034 Hold: load Pc=0x2000, then Ex_StallReq=1 for 3 cycles with Decode_Pc=0x3000 and StallReq=1 -> IDEX_Pc stays 0x2000, counter unchanged.
REQ-035 Flush priority: Ctrl_Flush=1, Ex_StallReq=1, Decode_Valid=1 same cycle -> next cycle IDEX_Valid=0, all fields 0.
REQ-036 Reset mid-hold: rst_n=0 while Ex_StallReq=1 and IDEX_BubbleCnt=7 -> outputs cleared, counter 0; after release LOAD in first cycle.
REQ-037 Saturation: force counter to 0xFFFF_FFFE, two stall cycles -> 0xFFFF_FFFF, stays there.
